dm_port_arbiter: RTL and testbench
==================================

# dm_port_arbiter

Two-requester arbiter and sequencer for the single-port data memory (DM). It shares the DM's one word-wide read/write port between requester 0 (CPU data stage) and requester 1 (debug/DMA port). Each request is granted by round-robin and then completed in a fixed 3-cycle sequence. Sub-word stores are implemented as a single-cycle read-merge-write using the DM's combinational read path.

## Interface
- `AW`, default 12: word-address width; matches the DM address width.
- `clk` input, 1: system clock; all state updates on the rising edge.
- `reset` input, 1: synchronous, active-high.
- `req0`/`req1` input, 1: request valid; must be held, with its payload stable, until the matching ack.
- `we0`/`we1` input, 1: 1 = write, 0 = read.
- `addr0`/`addr1` input, AW: word address.
- `be0`/`be1` input, 4: byte enables for writes; bit i selects byte i (`[8i+7:8i]`).
- `wd0`/`wd1` input, 32: write data (unshifted, byte lanes already aligned).
- `ack0`/`ack1` output, 1: one-cycle completion pulse.
- `rd0`/`rd1` output, 32: registered read data: the word value before any write of that transaction.
- `busy` output, 1: high while in state BUSY or ACK.
- `MemWrite` output, 1: DM write enable.
- `MemAddr` output, AW: DM word address.
- `MemWD` output, 32: DM write data.
- `MemReadData` input, 32: DM combinational read data for `MemAddr`.

## Operation
- **FSM states:** IDLE, BUSY, ACK.
- **IDLE:**
  - If neither request is asserted, stay in IDLE.
  - If exactly one request is asserted, grant it.
  - If both are asserted, grant the requester not served last. The `last` register resets to 1, so requester 0 wins the first tie.
  - On a grant: latch the grant id `g` and go to BUSY.
- **BUSY (exactly 1 cycle):**
  - Drive `MemAddr = addr_g`.
  - Capture `MemReadData` into `rd_g`.
  - If `we_g && be_g != 0`:
    - `MemWrite = 1`.
    - `MemWD` = per-byte merge: byte i is `wd_g` where `be_g[i]`, otherwise `MemReadData`.
    - The DM updates on the BUSY→ACK edge.
  - Go to ACK.
- **ACK (exactly 1 cycle):**
  - `ack_g = 1`; the other ack stays 0.
  - `rd_g` is valid this cycle and holds until that requester's next completion.
  - Set `last = g`; go to IDLE.
  - Requests are not sampled in ACK.
- **After an ack:** the acked requester either deasserts `req` or presents a new request; the arbiter samples it in IDLE on the next cycle.
- **Write with `be == 0`:** no DM write, but the sequence still completes and acks. `rd` returns the current word.
- **Idle drive values:** outside BUSY, `MemWrite = 0`, `MemAddr = 0`, `MemWD = 0`.
- **Write gating:** `MemWrite` is gated by `!reset`, so it is 0 during any reset cycle even if the state is BUSY.
- **Payload rule:** the payload is taken directly from the granted port's inputs during BUSY and is not latched. Requesters must hold it stable.

## Timing
- **Reset values:** state IDLE, `last = 1`, `ack0 = ack1 = 0`, `rd0 = rd1 = 0`, `busy = 0`, `MemWrite = 0`, `MemAddr = 0`, `MemWD = 0`.
- **Latency:** `req` sampled high in IDLE at edge k → BUSY in cycle k+1 (DM write at edge k+2) → ack high in cycle k+2.
- **Throughput:** one transaction per 3 cycles maximum. Under continuous contention the requesters strictly alternate.
- **Reset mid-operation:**
  - Reset in BUSY: no DM write, no ack, FSM returns to IDLE.
  - Reset in ACK: the ack pulse still appears that cycle, since ack is registered. The next cycle is IDLE with all reset values.
- **Simultaneous new requests:** if both requests assert in the same IDLE cycle, round-robin decides. If `req1` is asserted while requester 0 is being served, `req1` is granted at the next IDLE.
- **Address range:** the full 2^AW word range is accessible with no wrap logic; address width passes straight through.

## Test plan
- **Reset behaviour:** reset for 2 cycles with both requests high → all outputs 0, no ack. Release reset → requester 0 is granted first.
- **Single full-word write then read:** `req0`, `we0 = 1`, `addr0 = 12'h010`, `be0 = 4'hF`, `wd0 = 32'hDEADBEEF` → `MemWrite` high for exactly one cycle, `ack0` 2 cycles after sampling. Then a read of `12'h010` → `rd0 = 32'hDEADBEEF`.
- **Byte merge:** word `12'h010 = 32'hDEADBEEF`; `req1` writes `be1 = 4'b0010`, `wd1 = 32'h0000AA00` → `MemWD = 32'hDEADAAEF`, and `rd1` returns the old value `32'hDEADBEEF`.
- **Contention:** hold `req0` and `req1` continuously for 12 cycles with reads → ack sequence 0, 1, 0, 1, each separated by 3 cycles. No cycle has both acks high.
- **Zero byte enables:** write with `be0 = 4'h0` → `MemWrite` never asserts, `ack0` still pulses, `rd0` equals the stored word.
- **Reset in BUSY:** assert reset during BUSY of a write → the target word is unchanged and there is no ack. Reset in ACK → a single ack pulse, then idle.

Source files
------------

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares the single read/write port of the data memory
// between the CPU data stage (requester 0) and the debug/DMA port
// (requester 1). Ties are broken round-robin. Every transaction runs
// IDLE -> BUSY -> ACK. Sub-word stores read, merge and write the word in
// the single BUSY cycle, using the memory's combinational read path.
module dm_port_arbiter #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [3:0]    be0,
    input  logic [3:0]    be1,
    input  logic [31:0]   wd0,
    input  logic [31:0]   wd1,
    output logic          ack0,
    output logic          ack1,
    output logic [31:0]   rd0,
    output logic [31:0]   rd1,
    output logic          busy,
    output logic          MemWrite,
    output logic [AW-1:0] MemAddr,
    output logic [31:0]   MemWD,
    input  logic [31:0]   MemReadData
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t        state_q;
    logic          grant_q;     // id of the requester being served
    logic          last_q;      // id of the requester served most recently
    logic          ack0_q;
    logic          ack1_q;
    logic          busy_q;
    logic [31:0]   rd0_q;
    logic [31:0]   rd1_q;

    logic          grant_d;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [3:0]    sel_be;
    logic [31:0]   sel_wd;
    logic [31:0]   merged_wd;
    logic          do_write;

    // Route the granted requester's live payload to the memory side.
    // NOTE: every signal gets a default at the top of an always_comb so no path leaves it unassigned and infers a latch.
    always_comb begin
        sel_we   = we0;
        sel_addr = addr0;
        sel_be   = be0;
        sel_wd   = wd0;
        if (grant_q) begin
            sel_we   = we1;
            sel_addr = addr1;
            sel_be   = be1;
            sel_wd   = wd1;
        end
    end

    // Byte-lane merge of new write data over the current memory word.
    always_comb begin
        merged_wd = MemReadData;
        for (int i = 0; i < 4; i++) begin
            if (sel_be[i]) begin
                merged_wd[8*i +: 8] = sel_wd[8*i +: 8];
            end
        end
    end

    // Round-robin choice: a lone requester wins; on a tie, the one not served last.
    always_comb begin
        grant_d = req1;
        if (req0 && req1) begin
            grant_d = ~last_q;
        end
    end

    // A write with no byte enabled still completes but never touches memory.
    assign do_write = (state_q == ST_BUSY) && sel_we && (sel_be != 4'h0);

    // Memory port: driven only in BUSY, zero otherwise; the write is blocked during reset.
    always_comb begin
        MemWrite = do_write && !reset;
        MemAddr  = (state_q == ST_BUSY) ? sel_addr : '0;
        MemWD    = do_write ? merged_wd : 32'h0;
    end

    // Sequencer FSM with registered ack, read data and busy.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and active-high; it is only seen on a rising clock edge.
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            busy_q  <= 1'b0;
            rd0_q   <= 32'h0;
            rd1_q   <= 32'h0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        grant_q <= grant_d;
                        busy_q  <= 1'b1;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // The captured word is the value before this transaction's write.
                    if (grant_q) begin
                        rd1_q  <= MemReadData;
                        ack1_q <= 1'b1;
                    end else begin
                        rd0_q  <= MemReadData;
                        ack0_q <= 1'b1;
                    end
                    state_q <= ST_ACK;
                end
                ST_ACK: begin
                    last_q  <= grant_q;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack0 = ack0_q;
    assign ack1 = ack1_q;
    assign rd0  = rd0_q;
    assign rd1  = rd1_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Testbench for dm_port_arbiter: a memory model, a transaction-level reference
// model that schedules grants and completions, and a monitor that pops
// expected completions from a scoreboard queue whenever an ack appears.
module tb_dm_port_arbiter;

    localparam int AW    = 12;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        int          id;
        logic [31:0] rd;
        int          cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    req;
    logic [1:0]    we;
    logic [AW-1:0] addr [2];
    logic [3:0]    be   [2];
    logic [31:0]   wd   [2];
    logic          ack0;
    logic          ack1;
    logic [31:0]   rd0;
    logic [31:0]   rd1;
    logic          busy;
    logic          MemWrite;
    logic [AW-1:0] MemAddr;
    logic [31:0]   MemWD;
    logic [31:0]   MemReadData;

    // Memory model: an untouched word holds a fixed address-derived pattern.
    logic [31:0]   dm       [DEPTH];
    logic          dm_valid [DEPTH];
    logic [31:0]   ref_mem  [DEPTH];

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    exp_t          ack_q [$];
    int            ack_ids [$];
    int            ack_cycs [$];
    logic [1:0]    done = 2'b00;

    // Reference model state
    int            free_at = 0;
    int            m_last = 1;
    int            cur_id = 0;
    logic          cur_busy = 1'b0;
    logic          in_ack = 1'b0;
    exp_t          e_new;
    exp_t          e_got;

    dm_port_arbiter #(.AW(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .req0        (req[0]),
        .req1        (req[1]),
        .we0         (we[0]),
        .we1         (we[1]),
        .addr0       (addr[0]),
        .addr1       (addr[1]),
        .be0         (be[0]),
        .be1         (be[1]),
        .wd0         (wd[0]),
        .wd1         (wd[1]),
        .ack0        (ack0),
        .ack1        (ack1),
        .rd0         (rd0),
        .rd1         (rd1),
        .busy        (busy),
        .MemWrite    (MemWrite),
        .MemAddr     (MemAddr),
        .MemWD       (MemWD),
        .MemReadData (MemReadData)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input logic [AW-1:0] a);
        return (32'(a) + 32'd1) * 32'h9E3779B9;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] b);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Data memory: combinational read, write on the rising edge.
    assign MemReadData = dm_valid[MemAddr] ? dm[MemAddr] : init_word(MemAddr);

    always @(posedge clk) begin
        if (MemWrite) begin
            dm[MemAddr]       <= MemWD;
            dm_valid[MemAddr] <= 1'b1;
        end
    end

    // Reference model: a grant occupies the port for three edges; the word is
    // read and updated at the completion edge, which is also when the ack is due.
    always @(posedge clk) begin
        cyc++;
        in_ack = 1'b0;
        if (reset) begin
            cur_busy = 1'b0;
            m_last   = 1;
            free_at  = cyc + 1;
        end else if (cur_busy) begin
            e_new.id  = cur_id;
            e_new.rd  = ref_mem[addr[cur_id]];
            e_new.cyc = cyc;
            if (we[cur_id] && be[cur_id] != 4'h0)
                ref_mem[addr[cur_id]] = merge(ref_mem[addr[cur_id]], wd[cur_id], be[cur_id]);
            ack_q.push_back(e_new);
            m_last   = cur_id;
            cur_busy = 1'b0;
            in_ack   = 1'b1;
            free_at  = cyc + 2;
        end else if (cyc >= free_at && req != 2'b00) begin
            if (req == 2'b11) cur_id = 1 - m_last;
            else              cur_id = req[1] ? 1 : 0;
            cur_busy = 1'b1;
        end
    end

    // Monitor: per-cycle memory-port checks and scoreboard pops on every ack.
    always @(negedge clk) begin
        logic        exp_we;
        logic [31:0] exp_wd;
        if (cyc > 0) begin
            exp_we = cur_busy && we[cur_id] && (be[cur_id] != 4'h0);
            exp_wd = exp_we ? merge(ref_mem[addr[cur_id]], wd[cur_id], be[cur_id]) : 32'h0;
            check("both_acks", 32'(ack0 & ack1), 32'd0);
            check("MemWrite", 32'(MemWrite), 32'(exp_we && !reset));
            check("MemAddr", 32'(MemAddr), cur_busy ? 32'(addr[cur_id]) : 32'd0);
            check("MemWD", MemWD, exp_wd);
            check("busy", 32'(busy), 32'(cur_busy || in_ack));
            while (ack_q.size() > 0 && ack_q[0].cyc < cyc) begin
                check("ack_missing_at_cycle", 32'(cyc), 32'(ack_q[0].cyc));
                void'(ack_q.pop_front());
            end
            if (ack0 || ack1) begin
                if (ack_q.size() == 0) begin
                    check("unexpected_ack", 32'({ack1, ack0}), 32'd0);
                end else begin
                    e_got = ack_q.pop_front();
                    check("ack_id", 32'(ack1), 32'(e_got.id));
                    check("ack_cycle", 32'(cyc), 32'(e_got.cyc));
                    check("rd", e_got.id == 1 ? rd1 : rd0, e_got.rd);
                end
                done[ack1 ? 1 : 0] = 1'b1;
                ack_ids.push_back(ack1 ? 1 : 0);
                ack_cycs.push_back(cyc);
            end
        end
    end

    // Issue one request on port r and hold it until its ack.
    task automatic transact(input int r, input logic w, input logic [AW-1:0] a,
                            input logic [3:0] b, input logic [31:0] d);
        @(posedge clk); #1;
        done[r] = 1'b0;
        req[r]  = 1'b1;
        we[r]   = w;
        addr[r] = a;
        be[r]   = b;
        wd[r]   = d;
        for (int i = 0; i < 20 && !done[r]; i++) begin
            @(posedge clk); #1;
        end
        check("txn_completed", 32'(done[r]), 32'd1);
        req[r]  = 1'b0;
        done[r] = 1'b0;
    endtask

    // Drop each held request once it has been acked.
    task automatic drain();
        for (int i = 0; i < 60 && req != 2'b00; i++) begin
            @(posedge clk); #1;
            for (int r = 0; r < 2; r++) begin
                if (done[r]) begin
                    done[r] = 1'b0;
                    req[r]  = 1'b0;
                end
            end
        end
        check("drain_all_acked", 32'(req), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached with %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int          n0;
        logic [31:0] old_w;

        for (int i = 0; i < DEPTH; i++) begin
            dm_valid[i] = 1'b0;
            ref_mem[i]  = init_word(AW'(i));
        end
        reset = 1'b1;
        req   = 2'b11;
        we    = 2'b00;
        for (int r = 0; r < 2; r++) begin
            addr[r] = AW'(r);
            be[r]   = 4'h0;
            wd[r]   = 32'h0;
        end

        // Reset with both requests high: nothing moves, then requester 0 first.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_rd0", rd0, 32'h0);
        check("reset_rd1", rd1, 32'h0);
        check("reset_acks", 32'({ack1, ack0}), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        n0 = ack_ids.size();
        drain();
        check("first_grant_is_0", 32'(ack_ids[n0]), 32'd0);

        // Full-word write then read back.
        transact(0, 1'b1, 12'h010, 4'hF, 32'hDEADBEEF);
        transact(0, 1'b0, 12'h010, 4'h0, 32'h0);
        check("readback_full_word", rd0, 32'hDEADBEEF);

        // Byte merge from requester 1; rd1 returns the pre-write word.
        transact(1, 1'b1, 12'h010, 4'b0010, 32'h0000AA00);
        check("merge_old_value", rd1, 32'hDEADBEEF);
        transact(0, 1'b0, 12'h010, 4'h0, 32'h0);
        check("merge_result", rd0, 32'hDEADAAEF);

        // Zero byte enables: completes without writing.
        transact(0, 1'b1, 12'h010, 4'h0, 32'h12345678);
        check("zero_be_rd", rd0, 32'hDEADAAEF);
        transact(1, 1'b0, 12'h010, 4'h0, 32'h0);
        check("zero_be_unchanged", rd1, 32'hDEADAAEF);

        // Continuous contention: acks alternate, three cycles apart.
        @(posedge clk); #1;
        n0 = ack_ids.size();
        for (int r = 0; r < 2; r++) begin
            done[r] = 1'b0;
            we[r]   = 1'b0;
            addr[r] = AW'(12'h010 + r);
        end
        req = 2'b11;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            done = 2'b00;
        end
        drain();
        check("contention_ack_count_ge4", 32'(ack_ids.size() - n0 >= 4), 32'd1);
        for (int i = n0 + 1; i < ack_ids.size(); i++) begin
            check("contention_alternates", 32'(ack_ids[i] != ack_ids[i-1]), 32'd1);
            check("contention_spacing", 32'(ack_cycs[i] - ack_cycs[i-1]), 32'd3);
        end

        // Reset during BUSY of a write: no write and no ack.
        old_w = ref_mem[12'h020];
        n0 = ack_ids.size();
        @(posedge clk); #1;
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 12'h020; be[0] = 4'hF; wd[0] = 32'hCAFEF00D;
        for (int i = 0; i < 10 && !cur_busy; i++) begin
            @(posedge clk); #1;
        end
        check("reached_busy", 32'(cur_busy), 32'd1);
        reset  = 1'b1;
        req[0] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        check("reset_busy_no_ack", 32'(ack_ids.size() - n0), 32'd0);
        transact(0, 1'b0, 12'h020, 4'h0, 32'h0);
        check("reset_busy_word_kept", rd0, old_w);

        // Reset during ACK: the pulse still appears once, then idle.
        n0 = ack_ids.size();
        @(posedge clk); #1;
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 12'h030; be[1] = 4'h0;
        for (int i = 0; i < 10 && !in_ack; i++) begin
            @(posedge clk); #1;
        end
        check("reached_ack", 32'(in_ack), 32'd1);
        reset  = 1'b1;
        req[1] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        done  = 2'b00;
        @(negedge clk);
        check("reset_ack_rd1_cleared", rd1, 32'h0);
        check("reset_ack_idle", 32'({busy, ack1, ack0}), 32'd0);
        repeat (2) @(posedge clk);
        check("reset_ack_single_pulse", 32'(ack_ids.size() - n0), 32'd1);

        // Randomized traffic from both requesters.
        for (int c = 0; c < 800; c++) begin
            @(posedge clk); #1;
            for (int r = 0; r < 2; r++) begin
                if (done[r]) begin
                    done[r] = 1'b0;
                    req[r]  = 1'b0;
                end
                if (!req[r] && $urandom_range(0, 2) == 0) begin
                    req[r]  = 1'b1;
                    we[r]   = 1'($urandom_range(0, 1));
                    addr[r] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
                    be[r]   = 4'($urandom);
                    wd[r]   = $urandom;
                end
            end
        end
        drain();
        repeat (4) @(posedge clk);
        check("scoreboard_empty", 32'(ack_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
